// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit: one EXU result per transaction, memory access over a req/resp handshake, aligned/extended write-back data to the WBU.
// Optional macro LSU_MISALIGN_CHECK_EN: suppress misaligned accesses and flag them on o_misalign.
module ysyx_22050710_lsu #(
  parameter int GPRADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_alu_result,
  input  logic [DATA_WIDTH-1:0]    i_store_data,
  input  logic                     i_mem_ren,
  input  logic                     i_mem_wen,
  input  logic [2:0]               i_funct3,
  input  logic                     i_rf_wen,
  input  logic [GPRADDR_WIDTH-1:0] i_rf_waddr,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  output logic [ADDR_WIDTH-1:0]    o_mem_addr,
  output logic                     o_mem_wen,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  output logic [7:0]               o_mem_wmask,
  input  logic                     i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic                     o_valid,
  output logic                     o_rf_wen,
  output logic [GPRADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]    o_rf_wdata
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                     o_misalign
`endif
);

  // Handshake: a request is transferred on a cycle where o_mem_valid and
  // i_mem_ready are both high; read data is taken only when i_mem_rvalid is
  // high in WAIT or together with the accept of a load in REQ.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     mem_wen_q, mem_wen_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [7:0]               wmask_q, wmask_d;
  logic [2:0]               funct3_q, funct3_d;
  logic                     rf_wen_q, rf_wen_d;
  logic [GPRADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;

  logic [2:0]               in_off;
  logic [7:0]               size_mask;
  logic [7:0]               lane_mask;
  logic [DATA_WIDTH-1:0]    lane_wdata;
  logic                     is_mem, is_store;
  logic [DATA_WIDTH-1:0]    rd_shifted;
  logic [DATA_WIDTH-1:0]    load_ext;

  assign in_off     = i_alu_result[2:0];
  assign is_mem     = i_mem_ren | i_mem_wen;
  // A load wins when both ren and wen are set.
  assign is_store   = i_mem_wen & ~i_mem_ren;
  assign lane_mask  = size_mask << in_off;
  assign lane_wdata = i_store_data << {in_off, 3'b000};
  assign rd_shifted = i_mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    size_mask = 8'h01;
    case (i_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  always_comb begin
    load_ext = rd_shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){rd_shifted[7]}},   rd_shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){rd_shifted[31]}}, rd_shifted[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},  rd_shifted[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_off[0];
      2'b10:   misaligned = |in_off[1:0];
      default: misaligned = |in_off;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_wen_d  = mem_wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    funct3_d   = funct3_q;
    rf_wen_d   = rf_wen_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          addr_d     = ADDR_WIDTH'(i_alu_result);
          funct3_d   = i_funct3;
          mem_wen_d  = is_store;
          wmask_d    = is_store ? lane_mask : 8'h00;
          wdata_d    = is_store ? lane_wdata : '0;
          rf_wen_d   = i_rf_wen & ~is_store;
          rf_waddr_d = i_rf_waddr;
          rf_wdata_d = i_alu_result;
          state_d    = is_mem ? REQ : RESP;
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_d = is_mem & misaligned;
          if (is_mem && misaligned) begin
            state_d   = RESP;
            rf_wen_d  = 1'b0;
            mem_wen_d = 1'b0;
            wmask_d   = 8'h00;
          end
`endif
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          if (mem_wen_q) begin
            state_d = RESP;
          end else if (i_mem_rvalid) begin
            rf_wdata_d = load_ext;
            state_d    = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          rf_wdata_d = load_ext;
          state_d    = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_wen_q  <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= 8'h00;
      funct3_q   <= 3'b000;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_wen_q  <= mem_wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      funct3_q   <= funct3_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_mem_valid = (state_q == REQ);
  assign o_mem_addr  = addr_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_valid     = (state_q == RESP);
  assign o_rf_wen    = rf_wen_q;
  assign o_rf_waddr  = rf_waddr_q;
  assign o_rf_wdata  = rf_wdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign o_misalign  = (state_q == RESP) & misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Bench for ysyx_22050710_lsu: fixed vector table, hand-written reset/misalign sequences, randomized transactions vs a byte-level model.
module tb_ysyx_22050710_lsu;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_alu_result;
  logic [63:0] i_store_data;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [2:0]  i_funct3;
  logic        i_rf_wen;
  logic [4:0]  i_rf_waddr;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_wen;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_valid;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        o_misalign;
`endif

  ysyx_22050710_lsu dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_funct3(i_funct3),
    .i_rf_wen(i_rf_wen), .i_rf_waddr(i_rf_waddr),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_valid(o_valid), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
`ifdef LSU_MISALIGN_CHECK_EN
    , .o_misalign(o_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic        rfw;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          rdy;
    int          rv;
    bit          same;
    logic        exp_req;
    logic        exp_wen;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
    logic        exp_rfw;
    logic [63:0] exp_rfdata;
    logic        exp_mis;
  } txn_t;

  int n_total = 0;
  int n_bad   = 0;
  txn_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic txn_t mk_in(input logic ren, input logic wen, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] sdata,
                                 input logic rfw, input logic [4:0] rd, input logic [63:0] rdata,
                                 input int rdy, input int rv, input bit same);
    txn_t t;
    t.ren = ren; t.wen = wen; t.f3 = f3; t.addr = addr; t.sdata = sdata;
    t.rfw = rfw; t.rd = rd; t.rdata = rdata; t.rdy = rdy; t.rv = rv; t.same = same;
    t.exp_req = 0; t.exp_wen = 0; t.exp_mask = 0; t.exp_wdata = 0;
    t.exp_rfw = 0; t.exp_rfdata = 0; t.exp_mis = 0;
    return t;
  endfunction

  function automatic txn_t with_exp(input txn_t t, input logic req, input logic wen,
                                    input logic [7:0] mask, input logic [63:0] wdata,
                                    input logic rfw, input logic [63:0] rfdata, input logic mis);
    t.exp_req = req; t.exp_wen = wen; t.exp_mask = mask; t.exp_wdata = wdata;
    t.exp_rfw = rfw; t.exp_rfdata = rfdata; t.exp_mis = mis;
    return t;
  endfunction

  // Reference: byte-by-byte view of the lane rules.
  function automatic txn_t model(input txn_t t);
    int sz;
    int off;
    logic [63:0] val;
    bit mem;
    bit store;
    sz    = 1 << t.f3[1:0];
    off   = int'(t.addr[2:0]);
    mem   = t.ren | t.wen;
    store = t.wen & ~t.ren;
    t.exp_mis = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (mem && (off % sz) != 0) begin
      t.exp_req = 0; t.exp_wen = 0; t.exp_rfw = 0; t.exp_mis = 1;
      t.exp_mask = 0; t.exp_wdata = 0; t.exp_rfdata = 0;
      return t;
    end
`endif
    t.exp_req   = mem;
    t.exp_wen   = store;
    t.exp_mask  = 0;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + sz) t.exp_mask[b] = 1'b1;
    t.exp_wdata = t.sdata << (8 * off);
    val = 0;
    for (int i = 0; i < sz; i++)
      if (off + i < 8) val[8*i +: 8] = t.rdata[8*(off+i) +: 8];
    if (!t.f3[2] && sz < 8 && val[8*sz-1])
      for (int i = 8*sz; i < 64; i++) val[i] = 1'b1;
    t.exp_rfdata = t.ren ? val : t.addr;
    t.exp_rfw    = store ? 1'b0 : t.rfw;
    return t;
  endfunction

  task automatic idle_inputs();
    i_valid = 0; i_mem_ren = 0; i_mem_wen = 0; i_funct3 = 0; i_rf_wen = 0; i_rf_waddr = 0;
    i_alu_result = 0; i_store_data = 0; i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int cyc, req_cyc, wait_cyc, acc_cyc, val_cyc, exp_lat, got_lat;
    bit done, fields_ok, busy_ok;
    logic [63:0] first_addr, first_wdata;
    logic [7:0] first_mask;
    logic first_wen, got_rfw, got_mis;
    logic [4:0] got_rd;
    logic [63:0] got_rfdata;
    @(negedge clk);
    chk({tag, " ready_idle"}, o_ready, 1);
    i_valid = 1; i_mem_ren = t.ren; i_mem_wen = t.wen; i_funct3 = t.f3;
    i_alu_result = t.addr; i_store_data = t.sdata; i_rf_wen = t.rfw; i_rf_waddr = t.rd;
    cyc = 0; req_cyc = 0; wait_cyc = 0; acc_cyc = -1; val_cyc = -1;
    done = 0; fields_ok = 1; busy_ok = 1;
    first_addr = 0; first_wdata = 0; first_mask = 0; first_wen = 0;
    got_rfw = 0; got_mis = 0; got_rd = 0; got_rfdata = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      i_valid = 0; i_mem_ready = 0; i_mem_rvalid = 0;
      i_mem_rdata = {$urandom, $urandom};
      i_alu_result = {$urandom, $urandom}; i_store_data = {$urandom, $urandom};
      i_rf_waddr = 5'($urandom); i_funct3 = 3'($urandom);
      if (o_valid) begin
        got_rfw = o_rf_wen; got_rd = o_rf_waddr; got_rfdata = o_rf_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
        got_mis = o_misalign;
`endif
        val_cyc = cyc;
        done = 1;
      end else begin
        if (o_ready) busy_ok = 0;
        if (o_mem_valid) begin
          if (req_cyc == 0) begin
            first_addr = o_mem_addr; first_wen = o_mem_wen;
            first_mask = o_mem_wmask; first_wdata = o_mem_wdata;
          end
          if (o_mem_addr !== t.addr || o_mem_wen !== t.exp_wen) fields_ok = 0;
          if (t.exp_wen && (o_mem_wmask !== t.exp_mask || o_mem_wdata !== t.exp_wdata)) fields_ok = 0;
          req_cyc++;
          if (req_cyc == t.rdy + 1) begin
            i_mem_ready = 1;
            acc_cyc = cyc;
            if (t.ren && t.same) begin
              i_mem_rvalid = 1; i_mem_rdata = t.rdata;
            end
          end else begin
            i_mem_rvalid = 1'($urandom_range(0, 1));
          end
        end else if (acc_cyc >= 0) begin
          if (wait_cyc == t.rv) begin
            i_mem_rvalid = 1; i_mem_rdata = t.rdata;
          end
          wait_cyc++;
        end
      end
    end
    if (!done) chk({tag, " timeout"}, 0, 1);
    chk({tag, " busy_not_ready"}, busy_ok, 1);
    chk({tag, " req_seen"}, req_cyc > 0, t.exp_req);
    if (t.exp_req) begin
      chk({tag, " req_len"}, req_cyc, t.rdy + 1);
      chk({tag, " req_addr"}, first_addr, t.addr);
      chk({tag, " req_wen"}, first_wen, t.exp_wen);
      if (t.exp_wen) begin
        chk({tag, " req_wmask"}, first_mask, t.exp_mask);
        chk({tag, " req_wdata"}, first_wdata, t.exp_wdata);
      end
      chk({tag, " req_stable"}, fields_ok, 1);
    end
    if (!t.exp_req) begin
      exp_lat = 1; got_lat = val_cyc;
    end else begin
      exp_lat = (!t.ren || t.same) ? 1 : t.rv + 2;
      got_lat = val_cyc - acc_cyc;
    end
    chk({tag, " latency"}, got_lat, exp_lat);
    chk({tag, " rf_wen"}, got_rfw, t.exp_rfw);
    if (t.exp_rfw) begin
      chk({tag, " rf_waddr"}, got_rd, t.rd);
      chk({tag, " rf_wdata"}, got_rfdata, t.exp_rfdata);
    end
`ifdef LSU_MISALIGN_CHECK_EN
    chk({tag, " misalign"}, got_mis, t.exp_mis);
`endif
    @(negedge clk);
    i_mem_rvalid = 0;
    chk({tag, " valid_pulse"}, o_valid, 0);
    chk({tag, " back_idle"}, o_ready, 1);
  endtask

  initial begin
    txn_t t;
    idle_inputs();
    i_rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst o_valid", o_valid, 0);
    chk("rst o_mem_valid", o_mem_valid, 0);
    chk("rst o_mem_wen", o_mem_wen, 0);
    chk("rst o_rf_wen", o_rf_wen, 0);
    chk("rst o_ready", o_ready, 1);
    chk("rst o_mem_addr", o_mem_addr, 0);
    chk("rst o_mem_wdata", o_mem_wdata, 0);
    chk("rst o_mem_wmask", o_mem_wmask, 0);
    chk("rst o_rf_waddr", o_rf_waddr, 0);
    chk("rst o_rf_wdata", o_rf_wdata, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("rst o_misalign", o_misalign, 0);
`endif
    i_rst = 0;

    //                 ren wen f3      addr                   sdata                  rfw rd  rdata                  rdy rv same
    tbl[0]  = with_exp(mk_in(0, 0, 3'b000, 64'h1234,             64'h0,                 1, 5,  64'h0,                 0, 0, 0),
                       0, 0, 8'h00, 64'h0, 1, 64'h1234, 0);
    tbl[1]  = with_exp(mk_in(0, 1, 3'b000, 64'h8000_0003,        64'hAB,                1, 7,  64'h0,                 2, 0, 0),
                       1, 1, 8'h08, 64'hAB00_0000, 0, 64'h0, 0);
    tbl[2]  = with_exp(mk_in(1, 0, 3'b000, 64'h8000_0006,        64'h0,                 1, 10, 64'h0080_0000_0000_0000, 0, 1, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
    tbl[3]  = with_exp(mk_in(1, 0, 3'b100, 64'h8000_0006,        64'h0,                 1, 10, 64'h0080_0000_0000_0000, 1, 0, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'h80, 0);
    tbl[4]  = with_exp(mk_in(1, 0, 3'b010, 64'h8000_0000,        64'h0,                 1, 11, 64'h0000_0001_8000_0000, 0, 0, 1),
                       1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_8000_0000, 0);
    tbl[5]  = with_exp(mk_in(1, 0, 3'b011, 64'h8000_0008,        64'h0,                 1, 12, 64'h1122_3344_5566_7788, 1, 2, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'h1122_3344_5566_7788, 0);
    tbl[6]  = with_exp(mk_in(1, 0, 3'b101, 64'h8000_0002,        64'h0,                 1, 13, 64'h1122_3344_5566_7788, 0, 0, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'h5566, 0);
    tbl[7]  = with_exp(mk_in(0, 1, 3'b011, 64'h8000_0010,        64'hDEAD_BEEF_0123_4567, 0, 0, 64'h0,                0, 0, 0),
                       1, 1, 8'hFF, 64'hDEAD_BEEF_0123_4567, 0, 64'h0, 0);
    tbl[8]  = with_exp(mk_in(0, 1, 3'b001, 64'h8000_0006,        64'h1234,              0, 0,  64'h0,                 3, 0, 0),
                       1, 1, 8'hC0, 64'h1234_0000_0000_0000, 0, 64'h0, 0);
    tbl[9]  = with_exp(mk_in(1, 1, 3'b010, 64'h8000_0004,        64'h5555,              1, 14, 64'h7654_3210_0000_0000, 0, 1, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'h7654_3210, 0);
    tbl[10] = with_exp(mk_in(1, 0, 3'b110, 64'h8000_0004,        64'h0,                 1, 15, 64'h8765_4321_0000_0000, 0, 0, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'h8765_4321, 0);
    tbl[11] = with_exp(mk_in(1, 0, 3'b001, 64'h8000_0000,        64'h0,                 1, 16, 64'h0000_0000_0000_8001, 0, 0, 1),
                       1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8001, 0);
    tbl[12] = with_exp(mk_in(0, 0, 3'b000, 64'h5A5A,             64'h0,                 0, 17, 64'h0,                 0, 0, 0),
                       0, 0, 8'h00, 64'h0, 0, 64'h0, 0);
    tbl[13] = with_exp(mk_in(1, 0, 3'b111, 64'h8000_0018,        64'h0,                 1, 18, 64'hCAFE_F00D_8765_4321, 2, 1, 0),
                       1, 0, 8'h00, 64'h0, 1, 64'hCAFE_F00D_8765_4321, 0);

    for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a store request is pending.
    @(negedge clk);
    i_valid = 1; i_mem_wen = 1; i_mem_ren = 0; i_funct3 = 3'b011;
    i_alu_result = 64'h8000_0040; i_store_data = 64'h1; i_rf_wen = 0;
    @(negedge clk);
    idle_inputs();
    chk("rstreq mem_valid_before", o_mem_valid, 1);
    i_rst = 1;
    @(negedge clk);
    i_rst = 0;
    chk("rstreq mem_valid_after", o_mem_valid, 0);
    chk("rstreq ready", o_ready, 1);

    // Reset while a load is stalled in WAIT; a late rvalid must be ignored.
    @(negedge clk);
    i_valid = 1; i_mem_ren = 1; i_funct3 = 3'b011; i_alu_result = 64'h8000_0020; i_rf_wen = 1; i_rf_waddr = 9;
    @(negedge clk);
    idle_inputs();
    chk("rstwait req", o_mem_valid, 1);
    i_mem_ready = 1;
    @(negedge clk);
    i_mem_ready = 0;
    chk("rstwait in_wait", {o_mem_valid, o_ready, o_valid}, 3'b000);
    @(negedge clk);
    i_rst = 1;
    @(negedge clk);
    i_rst = 0;
    chk("rstwait mem_valid", o_mem_valid, 0);
    chk("rstwait ready", o_ready, 1);
    i_mem_rvalid = 1; i_mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    i_mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstwait no_valid%0d", k), o_valid, 0);
      @(negedge clk);
    end

    // Misaligned halfword load.
`ifdef LSU_MISALIGN_CHECK_EN
    i_valid = 1; i_mem_ren = 1; i_funct3 = 3'b001; i_alu_result = 64'h8000_0001; i_rf_wen = 1; i_rf_waddr = 3;
    @(negedge clk);
    idle_inputs();
    chk("mis mem_valid", o_mem_valid, 0);
    chk("mis valid", o_valid, 1);
    chk("mis flag", o_misalign, 1);
    chk("mis rf_wen", o_rf_wen, 0);
    @(negedge clk);
    chk("mis valid_pulse", o_valid, 0);
    chk("mis flag_clear", o_misalign, 0);
`else
    t = with_exp(mk_in(1, 0, 3'b001, 64'h8000_0001, 64'h0, 1, 3, 64'h1122_3344_5566_7788, 1, 1, 0),
                 1, 0, 8'h00, 64'h0, 1, 64'h6677, 0);
    run_txn(t, "mis_lh");
`endif

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 3);
      t = mk_in(op == 1 || op == 3, op == 2 || op == 3, 3'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      t = model(t);
      run_txn(t, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_lsu.md
Name: ysyx_22050710_lsu

Overview:
Load/store stage directly upstream of the write-back unit. Takes one EXU result per transaction and performs the data-memory access over a request/response handshake. Aligns and sign/zero-extends load data and presents rf_wen/rf_waddr/rf_wdata plus a one-cycle valid to the WBU. Non-memory instructions pass through with one registered cycle.

Parameters:
GPRADDR_WIDTH, 5, register-file address width
DATA_WIDTH, 64, GPR/bus data width (fixed 64; byte lanes = 8)
ADDR_WIDTH, 64, memory address width

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  EXU presents instruction
o_ready  output  1  LSU can accept (IDLE only)
i_alu_result  input  DATA_WIDTH  memory address, or rf result for non-mem op
i_store_data  input  DATA_WIDTH  rs2 value for stores
i_mem_ren  input  1  load
i_mem_wen  input  1  store
i_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 treated as D
i_rf_wen  input  1  instruction writes rd
i_rf_waddr  input  GPRADDR_WIDTH  rd
o_mem_valid  output  1  memory request
i_mem_ready  input  1  memory accepts request
o_mem_addr  output  ADDR_WIDTH  byte address (unmodified)
o_mem_wen  output  1  request is a write
o_mem_wdata  output  DATA_WIDTH  store data shifted to lane
o_mem_wmask  output  8  byte-lane mask
i_mem_rvalid  input  1  read data valid
i_mem_rdata  input  DATA_WIDTH  8-byte-aligned read word
o_valid  output  1  one-cycle pulse: rf outputs valid for WBU
o_rf_wen  output  1  to WBU
o_rf_waddr  output  GPRADDR_WIDTH  to WBU
o_rf_wdata  output  DATA_WIDTH  to WBU

Behaviour:
- Reset: state IDLE; o_valid, o_mem_valid, o_mem_wen, o_rf_wen = 0; all data/addr/mask outputs = 0.
- States IDLE, REQ, WAIT, RESP. o_ready = 1 only in IDLE.
- IDLE, i_valid: capture all inputs. If ren or wen -> REQ, else -> RESP with rf_wdata = i_alu_result. Latency 1 cycle for non-mem ops.
- REQ: o_mem_valid = 1, held with stable addr/wdata/wmask/wen until i_mem_ready.
  - Store accepted -> RESP, with rf_wen forced 0.
  - Load accepted -> WAIT.
  - Load accepted with i_mem_rvalid in the same cycle -> RESP directly, data captured.
- WAIT: hold until i_mem_rvalid, then capture extended data -> RESP. i_mem_rvalid outside WAIT, and outside the REQ accept cycle of a load, is ignored.
- RESP: o_valid = 1 for exactly one cycle; o_rf_* hold the captured values; -> IDLE. o_rf_* hold their value until the next capture.
- Lane rule, off = addr[2:0]:
  - wmask = size-mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << off, truncated to 8 bits.
  - wdata = store_data << 8*off.
  - Load: rdata >> 8*off, keep size bytes, sign-extend (B/H/W) or zero-extend (BU/HU/WU); D passes through.
- ren and wen both set: treated as load, no write issued.
- i_rst mid-transaction: next edge forces IDLE and drops o_mem_valid; any later rvalid is ignored.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: an access with off not a multiple of its size issues no memory request. State goes IDLE -> RESP; o_valid pulses with rf_wen = 0. Extra output o_misalign (1 bit) is asserted in that RESP cycle and is 0 at reset and otherwise.
- Undefined: no port o_misalign; misaligned access is issued with the truncated mask/shifted data per lane rule.

Test Plan:
- Non-mem op alu_result=0x1234, rd=5, rf_wen=1 -> o_valid one cycle later, o_rf_wdata=0x1234, waddr=5, no o_mem_valid.
- SB addr=0x8000_0003, store_data=0xAB, i_mem_ready after 2 wait cycles -> o_mem_valid held 3 cycles, wmask=0x08, wdata=0xAB<<24; o_valid with rf_wen=0.
- LB addr=0x...06, rdata=0x0080_0000_0000_0000 -> o_rf_wdata=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- LW, i_mem_ready and i_mem_rvalid in the same cycle, rdata=0x0000_0001_8000_0000, off=0 -> RESP next cycle, wdata=0xFFFF_FFFF_8000_0000.
- LD stalled in WAIT with i_rst asserted for one cycle -> IDLE, o_mem_valid=0; a subsequent rvalid produces no o_valid.
- (LSU_MISALIGN_CHECK_EN) LH addr=0x...01 -> no o_mem_valid; o_valid and o_misalign=1 one cycle later, rf_wen=0.
